// File: rtl/conv_slice_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_slice_feeder
// Purpose  : Raster-order pixel stream to vertical-slice converter feeding a
//            conv window buffer. Keeps DWIDTH_SLICE-1 previous rows in line
//            buffers and, for each accepted pixel, emits the column slice
//            {row-4 .. row-1, current} one cycle later.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - begins a frame when sampled high in IDLE
//            in_valid/in_ready/in_data - pixel input handshake
//            slice_data      - packed vertical slice, oldest row in MSBs
//            slice_wen       - slice_data valid (buffer write enable)
//            slice_pop       - commit strobe (buffer pop)
//            win_valid       - window holds DWIDTH_SLICE full slices of row
//            frame_done      - one-cycle end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module conv_slice_feeder #(
   parameter int DWIDTH_DAT   = 12,
   parameter int DWIDTH_SLICE = 5,
   parameter int IMG_W        = 64,
   parameter int IMG_H        = 48
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [DWIDTH_DAT-1:0]              in_data,
   output logic [DWIDTH_DAT*DWIDTH_SLICE-1:0] slice_data,
   output logic                               slice_wen,
   output logic                               slice_pop,
   output logic                               win_valid,
   output logic                               frame_done
);

   localparam int C_NUM_LB = DWIDTH_SLICE - 1;
   localparam int C_SLICE_W = DWIDTH_DAT * DWIDTH_SLICE;
   localparam int C_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int C_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [C_COL_W-1:0] C_COL_LAST      = C_COL_W'(IMG_W - 1);
   localparam logic [C_ROW_W-1:0] C_ROW_LAST      = C_ROW_W'(IMG_H - 1);
   localparam logic [C_ROW_W-1:0] C_ROW_FIRST_OUT = C_ROW_W'(DWIDTH_SLICE - 1);
   localparam logic [C_COL_W-1:0] C_COL_FIRST_WIN = C_COL_W'(DWIDTH_SLICE - 1);

   localparam logic [1:0] C_ST_IDLE = 2'd0;
   localparam logic [1:0] C_ST_RUN  = 2'd1;
   localparam logic [1:0] C_ST_DONE = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [C_COL_W-1:0]     col_q, col_d;
   logic [C_ROW_W-1:0]     row_q, row_d;
   logic [C_SLICE_W-1:0]   slice_data_q, slice_data_d;
   logic                   slice_wen_q, slice_wen_d;
   logic                   win_valid_q, win_valid_d;
   logic [DWIDTH_DAT-1:0]  lb_q [C_NUM_LB][IMG_W];
   logic [DWIDTH_DAT-1:0]  lb_d [C_NUM_LB][IMG_W];

   logic                   w_accept;
   logic                   w_last_pix;
   logic [C_SLICE_W-1:0]   w_slice;

   assign w_accept   = in_valid && (state_q == C_ST_RUN);
   assign w_last_pix = (row_q == C_ROW_LAST) && (col_q == C_COL_LAST);

   // Current pixel in the LSBs, then LB0 (newest previous row) upward to
   // the oldest row in the MSBs. Line buffers are read before the shift.
   assign w_slice[DWIDTH_DAT-1:0] = in_data;
   for (genvar gi = 0; gi < C_NUM_LB; gi++) begin : g_pack
      assign w_slice[(gi+2)*DWIDTH_DAT-1 -: DWIDTH_DAT] = lb_q[gi][col_q];
   end

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      lb_d         = lb_q;
      slice_data_d = slice_data_q;
      slice_wen_d  = 1'b0;
      win_valid_d  = 1'b0;

      case (state_q)
         C_ST_IDLE: begin
            if (start) begin
               state_d = C_ST_RUN;
               col_d   = '0;
               row_d   = '0;
            end
         end
         C_ST_RUN: begin
            if (w_accept && w_last_pix) begin
               state_d = C_ST_DONE;
            end
         end
         C_ST_DONE: begin
            state_d = C_ST_IDLE;
         end
         default: begin
            state_d = C_ST_IDLE;
         end
      endcase

      if (w_accept) begin
         slice_data_d = w_slice;
         // The first DWIDTH_SLICE-1 rows only prime the line buffers, so
         // whatever a previous frame left in them is never emitted.
         slice_wen_d  = (row_q >= C_ROW_FIRST_OUT);
         win_valid_d  = (row_q >= C_ROW_FIRST_OUT) && (col_q >= C_COL_FIRST_WIN);

         // Age the column by one row: LB0 takes the new pixel.
         lb_d[0][col_q] = in_data;
         for (int i = 1; i < C_NUM_LB; i++) begin
            lb_d[i][col_q] = lb_q[i-1][col_q];
         end

         if (col_q == C_COL_LAST) begin
            col_d = '0;
            row_d = (row_q == C_ROW_LAST) ? '0 : row_q + C_ROW_W'(1);
         end else begin
            col_d = col_q + C_COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= C_ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         slice_data_q <= '0;
         slice_wen_q  <= 1'b0;
         win_valid_q  <= 1'b0;
         for (int i = 0; i < C_NUM_LB; i++) begin
            for (int j = 0; j < IMG_W; j++) begin
               lb_q[i][j] <= '0;
            end
         end
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         slice_data_q <= slice_data_d;
         slice_wen_q  <= slice_wen_d;
         win_valid_q  <= win_valid_d;
         lb_q         <= lb_d;
      end
   end

   assign in_ready   = (state_q == C_ST_RUN);
   assign frame_done = (state_q == C_ST_DONE);
   assign slice_data = slice_data_q;
   assign slice_wen  = slice_wen_q;
   // Every written slice is committed in the same cycle.
   assign slice_pop  = slice_wen_q;
   assign win_valid  = win_valid_q;

endmodule
`default_nettype wire
